// File: rtl/dual_port_ram_bw.sv
// Byte-writable true dual-port RAM.
// - Read latency of 1 or 2 cycles.
// - Read-during-write behaviour is selectable: read_first or write_first.
// - After reset, an optional sweep clears every word to INIT_VALUE.
// - Flags a write/write collision when both ports write the same address in one cycle.
module dual_port_ram_bw #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    DEPTH         = 128,
    parameter int                    BYTE_WIDTH    = 8,
    parameter int                    LATENCY       = 1,
    parameter string                 WRITE_MODE    = "read_first",
    parameter int                    INIT_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
    localparam int                   NB            = DATA_WIDTH / BYTE_WIDTH,
    localparam int                   AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    input  logic                  ena,
    input  logic [NB-1:0]         wea,
    input  logic [AW-1:0]         addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    input  logic                  enb,
    input  logic [NB-1:0]         web,
    input  logic [AW-1:0]         addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  collision
);

    // Parameter legality, rejected at elaboration
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_err_lanes
        $error("dual_port_ram_bw: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_err_depth
        $error("dual_port_ram_bw: DEPTH must be a power of 2");
    end
    if ((LATENCY != 1) && (LATENCY != 2)) begin : g_err_latency
        $error("dual_port_ram_bw: LATENCY must be 1 or 2");
    end
    if ((WRITE_MODE != "read_first") && (WRITE_MODE != "write_first")) begin : g_err_mode
        $error("dual_port_ram_bw: WRITE_MODE must be read_first or write_first");
    end

    localparam bit WRITE_FIRST = (WRITE_MODE == "write_first");

    typedef enum logic {
        S_READY = 1'b0,
        S_INIT  = 1'b1
    } state_t;

    localparam state_t S_RESET = (INIT_ON_RESET != 0) ? S_INIT : S_READY;

    // Merge two lane-masked writes onto a word; the primary port wins overlapping lanes
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [NB-1:0]         pri_we,
        input logic [DATA_WIDTH-1:0] pri_din,
        input logic [NB-1:0]         sec_we,
        input logic [DATA_WIDTH-1:0] sec_din
    );
        logic [DATA_WIDTH-1:0] word;
        word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (pri_we[i]) begin
                word[i*BYTE_WIDTH +: BYTE_WIDTH] = pri_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else if (sec_we[i]) begin
                word[i*BYTE_WIDTH +: BYTE_WIDTH] = sec_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                word[i*BYTE_WIDTH +: BYTE_WIDTH] = old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return word;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    state_t                r_state;
    state_t                w_state_next;
    logic [AW-1:0]         r_cnt;
    logic                  w_sweep_we;
    logic                  w_sweep_last;

    logic                  w_ena;
    logic                  w_enb;
    logic [NB-1:0]         w_we_a;
    logic [NB-1:0]         w_we_b;
    logic                  w_same_addr;
    logic [DATA_WIDTH-1:0] w_old_a;
    logic [DATA_WIDTH-1:0] w_old_b;
    logic [DATA_WIDTH-1:0] w_wdata_a;
    logic [DATA_WIDTH-1:0] w_wdata_b;
    logic [DATA_WIDTH-1:0] w_rdata_a;
    logic [DATA_WIDTH-1:0] w_rdata_b;
    logic [DATA_WIDTH-1:0] r_douta_s1;
    logic [DATA_WIDTH-1:0] r_doutb_s1;
    logic                  r_collision;

    // FSM state register: clear sweep after reset, or straight to normal operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: leave INIT once the last address has been swept
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_INIT: begin
                if (w_sweep_last) begin
                    w_state_next = S_READY;
                end else begin
                    w_state_next = S_INIT;
                end
            end
            S_READY: w_state_next = S_READY;
            default: w_state_next = S_READY;
        endcase
    end

    // FSM outputs: sweep write strobe and last-address detect
    always_comb begin
        w_sweep_we   = 1'b0;
        w_sweep_last = 1'b0;
        case (r_state)
            S_INIT: begin
                w_sweep_we   = 1'b1;
                w_sweep_last = (r_cnt == AW'(DEPTH - 1));
            end
            S_READY: begin
                w_sweep_we   = 1'b0;
                w_sweep_last = 1'b0;
            end
            default: begin
                w_sweep_we   = 1'b0;
                w_sweep_last = 1'b0;
            end
        endcase
    end

    // Sweep address counter; restarts from 0 whenever reset is applied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_sweep_we) begin
            r_cnt <= r_cnt + AW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign init_busy = (r_state == S_INIT);

    // Port qualification, lane masks and merged write data for both addresses
    always_comb begin
        w_ena       = ena & ~init_busy;
        w_enb       = enb & ~init_busy;
        w_we_a      = w_ena ? wea : {NB{1'b0}};
        w_we_b      = w_enb ? web : {NB{1'b0}};
        w_same_addr = (addra == addrb);
        w_old_a     = r_mem[addra];
        w_old_b     = r_mem[addrb];
        // Port A keeps priority on shared lanes at a shared address, whichever word is merged
        w_wdata_a   = merge_lanes(w_old_a, w_we_a, dina,
                                  w_same_addr ? w_we_b : {NB{1'b0}}, dinb);
        w_wdata_b   = merge_lanes(w_old_b, w_same_addr ? w_we_a : {NB{1'b0}}, dina,
                                  w_we_b, dinb);
        if (WRITE_FIRST) begin
            w_rdata_a = w_wdata_a;
            w_rdata_b = w_wdata_b;
        end else begin
            w_rdata_a = w_old_a;
            w_rdata_b = w_old_b;
        end
    end

    // Array update: sweep has the array to itself; otherwise full merged words are written
    always_ff @(posedge clk) begin
        if (w_sweep_we && !rst) begin
            r_mem[r_cnt] <= INIT_VALUE;
        end else begin
            if (|w_we_a) begin
                r_mem[addra] <= w_wdata_a;
            end
            if (|w_we_b) begin
                r_mem[addrb] <= w_wdata_b;
            end
        end
    end

    // First read stage: loads only on an enabled access, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_douta_s1 <= '0;
            r_doutb_s1 <= '0;
        end else begin
            if (w_ena) begin
                r_douta_s1 <= w_rdata_a;
            end
            if (w_enb) begin
                r_doutb_s1 <= w_rdata_b;
            end
        end
    end

    // Collision flag: both ports wrote one address last cycle, lane masks irrelevant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= (|w_we_a) & (|w_we_b) & w_same_addr;
        end
    end

    assign collision = r_collision;

    if (LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] r_douta_s2;
        logic [DATA_WIDTH-1:0] r_doutb_s2;

        // Second read stage: free-running copy of the first stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_douta_s2 <= '0;
                r_doutb_s2 <= '0;
            end else begin
                r_douta_s2 <= r_douta_s1;
                r_doutb_s2 <= r_doutb_s1;
            end
        end

        assign douta = r_douta_s2;
        assign doutb = r_doutb_s2;
    end else begin : g_lat1
        assign douta = r_douta_s1;
        assign doutb = r_doutb_s1;
    end

endmodule
